// File: rtl/dlsc_pcie_s6_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_pcie_s6_pkg
// Desc     : Shared TLP/AXI constants and outbound-write FSM state encoding.
// Revision : 1.0
// ============================================================================
package dlsc_pcie_s6_pkg;

    localparam logic [1:0] FMT_3DW_DATA = 2'b10;
    localparam logic [4:0] TYPE_MEM     = 5'b00000;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        H0      = 3'd2,
        H1      = 3'd3,
        H2      = 3'd4,
        PAYLOAD = 3'd5,
        RESP    = 3'd6
    } ow_state_t;

    // First header DW of a 3DW memory write; TC/TD/EP/attr all zero.
    function automatic logic [31:0] tlp_mwr_h0(input logic [9:0] length);
        return {1'b0, FMT_3DW_DATA, TYPE_MEM, 8'h00, 6'h00, length};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlsc_pcie_s6_outbound_write_if.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_pcie_s6_outbound_write_if
// Desc     : AXI write slave channels plus TX TLP stream of the outbound writer.
// Revision : 1.0
// ============================================================================
interface dlsc_pcie_s6_outbound_write_if #(
    parameter int ADDR = 32,
    parameter int LEN  = 4
);
    logic            axi_aw_ready;
    logic            axi_aw_valid;
    logic [ADDR-1:0] axi_aw_addr;
    logic [LEN-1:0]  axi_aw_len;
    logic            axi_w_ready;
    logic            axi_w_valid;
    logic            axi_w_last;
    logic [31:0]     axi_w_data;
    logic [3:0]      axi_w_strb;
    logic            axi_b_ready;
    logic            axi_b_valid;
    logic [1:0]      axi_b_resp;
    logic            tx_ready;
    logic            tx_valid;
    logic [31:0]     tx_data;
    logic            tx_last;

    modport slave (
        output axi_aw_ready, input  axi_aw_valid, input axi_aw_addr, input axi_aw_len,
        output axi_w_ready,  input  axi_w_valid,  input axi_w_last,  input axi_w_data,
        input  axi_w_strb,
        input  axi_b_ready,  output axi_b_valid,  output axi_b_resp,
        input  tx_ready,     output tx_valid,     output tx_data,    output tx_last
    );

    modport master (
        input  axi_aw_ready, output axi_aw_valid, output axi_aw_addr, output axi_aw_len,
        input  axi_w_ready,  output axi_w_valid,  output axi_w_last,  output axi_w_data,
        output axi_w_strb,
        output axi_b_ready,  input  axi_b_valid,  input  axi_b_resp,
        output tx_ready,     input  tx_valid,     input  tx_data,     input  tx_last
    );

endinterface
`default_nettype wire

// File: rtl/dlsc_pcie_s6_outbound_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_pcie_s6_outbound_write_buffer
// Desc     : 2^LEN x 36 burst buffer {strb, data}; sync write, async read.
// Revision : 1.0
// ============================================================================
module dlsc_pcie_s6_outbound_write_buffer #(
    parameter int LEN = 4
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [LEN-1:0] wr_addr,
    input  logic [35:0]    wr_data,
    input  logic [LEN-1:0] rd_addr,
    output logic [35:0]    rd_data
);

    logic [35:0] r_mem [1<<LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/dlsc_pcie_s6_outbound_write.sv
`default_nettype none
// ============================================================================
// Module   : dlsc_pcie_s6_outbound_write
// Desc     : Buffers one AXI write burst and emits it as a 3DW MWr TLP.
// Config   : DLSC_PCIE_OUTBOUND_WRITE_STRB_CHECK_EN rejects sparse strobes.
// Revision : 1.0
// ============================================================================
module dlsc_pcie_s6_outbound_write
    import dlsc_pcie_s6_pkg::*;
#(
    parameter int ADDR = 32,
    parameter int LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    dlsc_pcie_s6_outbound_write_if.slave  bus,
    input  logic                          bus_master_en,
    input  logic [7:0]                    bus_number,
    input  logic [4:0]                    dev_number,
    input  logic [2:0]                    func_number
);

    ow_state_t      r_state, w_state_nx;
    logic [31:0]    r_addr, w_addr_nx;
    logic [LEN-1:0] r_len, w_len_nx;
    logic [LEN-1:0] r_count, w_count_nx;
    logic [LEN-1:0] r_rd_count, w_rd_count_nx;
    logic           r_err, w_err_nx;
    logic [3:0]     r_first_be, w_first_be_nx;

    logic           r_aw_ready, r_w_ready, r_b_valid, r_tx_valid, r_tx_last;
    logic [31:0]    r_tx_data;
    logic [1:0]     r_b_resp;
    logic [31:0]    w_tx_data_nx;

    logic [ADDR-1:0] w_aw_addr;
    logic            w_aw_hs, w_w_hs, w_tx_hs, w_b_hs;
    logic            w_first_beat, w_final_beat, w_wr_en;
    logic [LEN-1:0]  w_buf_raddr;
    logic [35:0]     w_rd_word;
    logic [3:0]      w_last_be;

    assign w_aw_addr    = bus.axi_aw_addr;
    assign w_aw_hs      = r_aw_ready & bus.axi_aw_valid;
    assign w_w_hs       = r_w_ready  & bus.axi_w_valid;
    assign w_tx_hs      = r_tx_valid & bus.tx_ready;
    assign w_b_hs       = r_b_valid  & bus.axi_b_ready;
    assign w_first_beat = (r_count == '0);
    assign w_final_beat = (r_count == r_len);

    // H1 needs the last beat's strobe, so the read port points at beat len then.
    assign w_buf_raddr  = (w_state_nx == H1) ? w_len_nx : w_rd_count_nx;
    assign w_last_be    = (w_len_nx == '0) ? 4'h0 : w_rd_word[35:32];

    dlsc_pcie_s6_outbound_write_buffer #(.LEN(LEN)) u_buffer (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (r_count),
        .wr_data ({bus.axi_w_strb, bus.axi_w_data}),
        .rd_addr (w_buf_raddr),
        .rd_data (w_rd_word)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_len_nx      = r_len;
        w_count_nx    = r_count;
        w_rd_count_nx = r_rd_count;
        w_err_nx      = r_err;
        w_first_be_nx = r_first_be;
        w_wr_en       = 1'b0;
        case (r_state)
            IDLE: if (w_aw_hs) begin
                w_addr_nx  = 32'(w_aw_addr);
                w_len_nx   = bus.axi_aw_len;
                w_count_nx = '0;
                w_err_nx   = 1'b0;
                w_state_nx = DATA;
            end
            DATA: if (w_w_hs) begin
                w_wr_en    = 1'b1;
                w_count_nx = r_count + LEN'(1);
                if (w_first_beat) w_first_be_nx = bus.axi_w_strb;
                if (bus.axi_w_last != w_final_beat) w_err_nx = 1'b1;
`ifdef DLSC_PCIE_OUTBOUND_WRITE_STRB_CHECK_EN
                if (!w_first_beat && !w_final_beat && bus.axi_w_strb != 4'hF) w_err_nx = 1'b1;
                if (r_len != '0 && (w_first_beat || w_final_beat) && bus.axi_w_strb == 4'h0)
                    w_err_nx = 1'b1;
`endif
                if (w_final_beat) begin
                    if (!bus_master_en) w_err_nx = 1'b1;
                    w_rd_count_nx = '0;
                    w_state_nx    = w_err_nx ? RESP : H0;
                end
            end
            H0:      if (w_tx_hs) w_state_nx = H1;
            H1:      if (w_tx_hs) w_state_nx = H2;
            H2:      if (w_tx_hs) w_state_nx = PAYLOAD;
            PAYLOAD: if (w_tx_hs) begin
                if (r_tx_last) w_state_nx    = RESP;
                else           w_rd_count_nx = r_rd_count + LEN'(1);
            end
            RESP:    if (w_b_hs) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase

        case (w_state_nx)
            H0:      w_tx_data_nx = tlp_mwr_h0(10'(w_len_nx) + 10'd1);
            H1:      w_tx_data_nx = {bus_number, dev_number, func_number, 8'h00,
                                     w_last_be, w_first_be_nx};
            H2:      w_tx_data_nx = w_addr_nx & 32'hFFFF_FFFC;
            PAYLOAD: w_tx_data_nx = w_rd_word[31:0];
            default: w_tx_data_nx = 32'h0;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_rd_count <= '0;
            r_err      <= 1'b0;
            r_first_be <= 4'h0;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= RESP_OKAY;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_tx_data  <= 32'h0;
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_len      <= w_len_nx;
            r_count    <= w_count_nx;
            r_rd_count <= w_rd_count_nx;
            r_err      <= w_err_nx;
            r_first_be <= w_first_be_nx;
            r_aw_ready <= (w_state_nx == IDLE);
            r_w_ready  <= (w_state_nx == DATA);
            r_b_valid  <= (w_state_nx == RESP);
            r_b_resp   <= (w_state_nx == RESP && w_err_nx) ? RESP_SLVERR : RESP_OKAY;
            r_tx_valid <= (w_state_nx == H0) || (w_state_nx == H1) ||
                          (w_state_nx == H2) || (w_state_nx == PAYLOAD);
            r_tx_last  <= (w_state_nx == PAYLOAD) && (w_rd_count_nx == w_len_nx);
            r_tx_data  <= w_tx_data_nx;
        end
    end

    assign bus.axi_aw_ready = r_aw_ready;
    assign bus.axi_w_ready  = r_w_ready;
    assign bus.axi_b_valid  = r_b_valid;
    assign bus.axi_b_resp   = r_b_resp;
    assign bus.tx_valid     = r_tx_valid;
    assign bus.tx_data      = r_tx_data;
    assign bus.tx_last      = r_tx_last;

endmodule
`default_nettype wire

// File: doc/dlsc_pcie_s6_outbound_write.md
# dlsc_pcie_s6_outbound_write

AXI-slave-to-PCIe outbound posted-write engine for the Spartan-6 PCIe endpoint. It accepts one AXI write burst at a time and buffers the full burst. It emits the burst as a single 3DW Memory Write request TLP on the transmit TLP stream, then returns the AXI write response. It is the initiator-side counterpart of the inbound write path and feeds the outbound TX arbiter.

## Interface
Parameters:
- ADDR, 32, AXI address width (3..32); zero-extended into the 32-bit TLP address.
- LEN, 4, AXI burst length width; the internal buffer holds 2^LEN 32-bit words plus 4-bit strobes.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- axi_aw_ready  out  1  write command ready.
- axi_aw_valid  in  1  write command valid.
- axi_aw_addr  in  ADDR  byte address; bits [1:0] ignored.
- axi_aw_len  in  LEN  beats minus one.
- axi_w_ready  out  1  write data ready.
- axi_w_valid  in  1  write data valid.
- axi_w_last  in  1  last beat; checked, not used for termination.
- axi_w_data  in  32  write data.
- axi_w_strb  in  4  byte strobes.
- axi_b_ready  in  1  response ready.
- axi_b_valid  out  1  response valid.
- axi_b_resp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- bus_master_en  in  1  PCIe command register Bus Master Enable.
- bus_number  in  8  requester ID bus.
- dev_number  in  5  requester ID device.
- func_number  in  3  requester ID function.
- tx_ready  in  1  TLP sink ready.
- tx_valid  out  1  TLP word valid.
- tx_data  out  32  TLP word.
- tx_last  out  1  last TLP word.

## Operation
- FSM states: IDLE, DATA, H0, H1, H2, PAYLOAD, RESP. One burst is in flight at a time.
- IDLE: axi_aw_ready=1. On AW handshake, latch addr[31:2], len; clear beat count and error flag → DATA.
- DATA: axi_w_ready=1. Each W handshake writes data/strb to buffer[count] and increments count. Beat 0 strb → first_be; final beat strb → last_be.
- DATA ends at count==len. Error flag is set if w_last is 0 on the final beat or 1 on an earlier one. After the final beat: → RESP if error or !bus_master_en (sampled on the final beat), else → H0.
- Header words (fmt/type = 3DW MWr, TC/TD/EP/attr/tag = 0):
  - H0: {1'b0,2'b10,5'b00000,8'h00,6'h00,length}, where length = len+1 (10 bits).
  - H1: {bus,dev,func,8'h00,last_be,first_be}. last_be is 4'h0 when len==0.
  - H2: {addr[31:2],2'b00}.
- PAYLOAD: tx_data = buffer[rd_count], with combinational buffer read. tx_last when rd_count==len. Payload passes unmodified.
- Each state advances on tx_valid&tx_ready. After the tx_last handshake → RESP.
- RESP: axi_b_valid=1, resp OKAY or SLVERR. On b handshake → IDLE.
- Burst address arithmetic is not checked. The AXI master guarantees no 4KB crossing. Maximum payload is 2^LEN×4 bytes, which must be ≤128.

## Timing
- Reset: state=IDLE. axi_aw_ready, axi_w_ready, axi_b_valid, tx_valid, tx_last are 0; tx_data, axi_b_resp are 0.
- All outputs are registered. axi_aw_ready rises on the first clk after rst_n deasserts.
- Transitions take effect the cycle after the causing handshake. An N-beat burst with W back-to-back:
  - AW handshake at cycle 0; W beats at cycles 1..N.
  - H0 valid at N+1; with tx_ready held high, tx_last at N+3+N.
  - b_valid one cycle after the tx_last handshake.
- tx_valid stays high and tx_data stays stable until the handshake; no bubbles between TLP words when tx_ready=1.
- axi_aw_ready is low from AW accept until the b handshake completes.
- Reset asserted mid-burst or mid-TLP: immediate return to reset values; a partial TLP is abandoned, and the downstream arbiter is reset with this block.

## Configuration
- DLSC_PCIE_OUTBOUND_WRITE_STRB_CHECK_EN defined: the error flag is also set if any middle beat (not first, not last) has strb≠4'hF, or if len>0 and either first_be or last_be is 4'h0. A flagged burst emits no TLP and responds SLVERR.
- Undefined: strobes of middle beats are ignored and the TLP is emitted with full-DW payload.

## Structure
- Shared package dlsc_pcie_s6_pkg: TLP fmt/type constants (FMT_3DW_DATA, TYPE_MEM), AXI resp constants (RESP_OKAY, RESP_SLVERR), FSM state encoding.
- Sub-module dlsc_pcie_s6_outbound_write_buffer: 2^LEN×36 register array with a synchronous write port and combinational read port.

## Test plan
- Single beat, addr 0x1000_0004, strb 4'h3, data 0xA5A5A5A5 → TLP 0x40000001, {ID,8'h00,4'h0,4'h3}, 0x10000004, 0xA5A5A5A5 with tx_last; then resp OKAY.
- 16-beat burst, first strb 4'hC, last 4'h1, tx_ready toggling 50% → length 16, BE word ends 8'h1C, all 16 payload words in order, tx_data stable while stalled.
- bus_master_en=0 during a 4-beat burst → no tx_valid; axi_b_resp=2'b10.
- w_last asserted on beat 2 of a 4-beat burst → all 4 beats accepted; no TLP; SLVERR.
- With STRB_CHECK_EN, middle strb 4'h7 → SLVERR with no TLP. Without STRB_CHECK_EN → TLP emitted and OKAY.
- rst_n pulsed low after H1 is accepted → all outputs 0 immediately; next burst produces a correct complete TLP.
